nibble_serial_addsub: RTL

Multi-cycle WIDTH-bit adder/subtractor for the NPC ALU slow path and for small-area configurations.
- Processes one 4-bit slice per cycle, LSB nibble first, through a 4-bit lookahead slice.
- Subtraction is a + ~b + 1; addition is a + b + 0.
- Sits behind a valid/ready request channel and drives a valid/ready result channel toward the EXU writeback mux.

---
 rtl/nibble_serial_addsub_pkg.sv | 14 +
 rtl/nibble_serial_addsub_cla_slice4.sv | 29 ++
 rtl/nibble_serial_addsub.sv | 111 +++++++++++
 3 files changed

// File: rtl/nibble_serial_addsub_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor: FSM encoding and sizing defaults.
package nibble_serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_STEPS = DEF_WIDTH / 4;
    localparam int DEF_CNT_W = $clog2(DEF_STEPS);

endpackage

// File: rtl/nibble_serial_addsub_cla_slice4.sv
// 4-bit carry-lookahead slice; all carries are formed directly from generate/propagate terms.
module cla_slice4
    import nibble_serial_addsub_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle adder/subtractor: one nibble per cycle, LSB first, behind valid/ready channels.
//   state | meaning
//   IDLE  | ready for a request, last result no longer presented as valid
//   RUN   | stepping nibbles through the lookahead slice
//   DONE  | result and flags held with out_valid=1 until consumed
module nibble_serial_addsub
    import nibble_serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_cb,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int STEPS = WIDTH / 4;
    localparam int CW    = $clog2(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             c_q;
    logic             sub_q;
    logic             sa;
    logic             sb;
    logic [CW-1:0]    cnt;

    logic [3:0]       s_sum;
    logic             s_cout;
    logic [WIDTH-1:0] res_next;

    cla_slice4 u_slice (
        .a    (a_q[3:0]),
        .b    (b_q[3:0]),
        .cin  (c_q),
        .sum  (s_sum),
        .cout (s_cout)
    );

    assign res_next  = {s_sum, res_q[WIDTH-1:4]};
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // out_res is a separate capture register so the shifting partial sum is never visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            c_q      <= 1'b0;
            sub_q    <= 1'b0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            cnt      <= '0;
            out_res  <= '0;
            out_cb   <= 1'b0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_sub ? ~in_b : in_b;
                        c_q   <= in_sub;
                        sub_q <= in_sub;
                        sa    <= in_a[WIDTH-1];
                        sb    <= in_sub ? ~in_b[WIDTH-1] : in_b[WIDTH-1];
                        res_q <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 4;
                    b_q   <= b_q >> 4;
                    res_q <= res_next;
                    c_q   <= s_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        out_res  <= res_next;
                        out_cb   <= sub_q ^ s_cout;
                        out_ovf  <= (sa == sb) && (res_next[WIDTH-1] != sa);
                        out_zero <= ~|res_next;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
